// File: rtl/trng_collector.sv
// -----------------------------------------------------------------------------
// trng_collector
//   Consumer end of the ring-oscillator TRNG. Registers the bus enable onto the
//   TRNG enable and samples the raw TRNG bit on a divided strobe. A
//   repetition-count health test runs on the raw samples. Accepted bits are
//   packed MSB-first into WORD_WIDTH-bit words. Words are handed out through a
//   one-entry valid/ready buffer.
//
//   Optional feature: define TRNG_VON_NEUMANN_EN to debias the raw samples.
//   Samples are taken in pairs: 10 gives 1, 01 gives 0, and 00/11 are
//   discarded. The health test is unaffected.
//
// Ports
//   clk          sampling / system clock
//   reset_n      asynchronous active-low reset
//   enable       collector enable from the bus register
//   trng_en      enable to the TRNG oscillators (enable delayed one cycle)
//   trng_in      raw TRNG bit
//   rdata        random word; held stable while rvalid=1
//   rvalid       rdata holds an unread word
//   rready       consumer accepts the word (pop when rvalid && rready)
//   health_fail  sticky repetition-count failure; cleared by enable=0
// -----------------------------------------------------------------------------
module trng_collector #(
    parameter int WORD_WIDTH = 32,
    parameter int SAMPLE_DIV = 4,
    parameter int REP_LIMIT  = 24
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    output logic                  trng_en,
    input  logic                  trng_in,
    output logic [WORD_WIDTH-1:0] rdata,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  health_fail
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int CNT_W = $clog2(WORD_WIDTH + 1);
    localparam int REP_W = $clog2(REP_LIMIT + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_WIDTH - 1);
    localparam logic [REP_W-1:0] REP_MAX  = REP_W'(REP_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD,
        FAIL
    } state_t;

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      div_q;
    logic [CNT_W-1:0]      bitcnt_q;
    logic [WORD_WIDTH-1:0] shreg_q;
    logic [REP_W-1:0]      rep_q;
    logic                  prev_q;

    logic                  strobe;
    logic [REP_W-1:0]      rep_nxt;
    logic                  rep_trip;
    logic                  bit_ok;
    logic                  bit_val;

    logic                  sample_en;
    logic                  accept;
    logic                  load;
    logic                  trip;

    // The divider only advances while trng_en is high. It is forced to zero
    // while enable is low, so every enable rising edge restarts it from zero.
    assign strobe = trng_en && (div_q == DIV_LAST);

    // A run starts at 1. The first sample after a clear (rep_q == 0) has no
    // predecessor, so it also starts a new run.
    assign rep_nxt  = ((rep_q != '0) && (trng_in == prev_q)) ? rep_q + REP_W'(1) : REP_W'(1);
    assign rep_trip = (rep_nxt == REP_MAX);

`ifdef TRNG_VON_NEUMANN_EN
    logic vn_have_q;
    logic vn_first_q;

    // A bit is produced only on the second sample of a pair, and only when
    // the two samples differ. The produced bit is the first sample.
    assign bit_ok  = vn_have_q && (vn_first_q != trng_in);
    assign bit_val = vn_first_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vn_have_q  <= 1'b0;
            vn_first_q <= 1'b0;
        end else if (!enable || trip || load) begin
            vn_have_q  <= 1'b0;
        end else if (sample_en) begin
            vn_have_q  <= ~vn_have_q;
            if (!vn_have_q) begin
                vn_first_q <= trng_in;
            end
        end
    end
`else
    assign bit_ok  = 1'b1;
    assign bit_val = trng_in;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sample_en = 1'b0;
        accept    = 1'b0;
        load      = 1'b0;
        trip      = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (strobe) begin
                    sample_en = 1'b1;
                    // A health trip wins over a word completing on the same sample.
                    if (rep_trip) begin
                        trip    = 1'b1;
                        state_d = FAIL;
                    end else if (bit_ok) begin
                        accept = 1'b1;
                        if (bitcnt_q == CNT_LAST) begin
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (!rvalid || rready) begin
                    load    = 1'b1;
                    state_d = COLLECT;
                end
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!enable) begin
            state_d   = IDLE;
            sample_en = 1'b0;
            accept    = 1'b0;
            load      = 1'b0;
            trip      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trng_en     <= 1'b0;
            div_q       <= '0;
            rep_q       <= '0;
            prev_q      <= 1'b0;
            health_fail <= 1'b0;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            rdata       <= '0;
            rvalid      <= 1'b0;
        end else begin
            trng_en <= enable;

            if (!enable) begin
                div_q <= '0;
            end else if (trng_en) begin
                div_q <= strobe ? '0 : div_q + DIV_W'(1);
            end

            if (!enable) begin
                rep_q  <= '0;
                prev_q <= 1'b0;
            end else if (sample_en) begin
                rep_q  <= rep_nxt;
                prev_q <= trng_in;
            end

            if (!enable) begin
                health_fail <= 1'b0;
            end else if (trip) begin
                health_fail <= 1'b1;
            end

            if (!enable || trip) begin
                bitcnt_q <= '0;
                shreg_q  <= '0;
            end else if (accept) begin
                shreg_q  <= {shreg_q[WORD_WIDTH-2:0], bit_val};
                bitcnt_q <= bitcnt_q + CNT_W'(1);
            end else if (load) begin
                bitcnt_q <= '0;
            end

            // The output buffer ignores enable and FAIL. An unread word stays
            // until it is popped. A load on the same edge as a pop replaces the
            // popped word, so rvalid stays high.
            if (load) begin
                rdata  <= shreg_q;
                rvalid <= 1'b1;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_trng_collector.sv
module tb_trng_collector;

    localparam int W  = 32;
    localparam int SD = 4;
    localparam int RL = 24;

    logic         clk;
    logic         reset_n;
    logic         enable;
    logic         trng_en;
    logic         trng_in;
    logic [W-1:0] rdata;
    logic         rvalid;
    logic         rready;
    logic         health_fail;

    int n_cmp = 0;
    int n_mis = 0;

    trng_collector #(
        .WORD_WIDTH(W),
        .SAMPLE_DIV(SD),
        .REP_LIMIT (RL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .trng_en    (trng_en),
        .trng_in    (trng_in),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .rready     (rready),
        .health_fail(health_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: a list of accepted bits, a one-word buffer, a run
    // length and an enable age used to place the sample strobes.
    typedef enum {M_IDLE, M_COLLECT, M_HOLD, M_FAIL} mphase_t;

    mphase_t     m_ph;
    bit          m_en;
    int          m_age;
    bit          m_bits[$];
    logic [63:0] m_data;
    bit          m_valid;
    bit          m_hf;
    int          m_rep;
    bit          m_prev;
    bit          m_vn_have;
    bit          m_vn_first;

    bit feed[$];
    bit sticky;

    task automatic model_reset();
        m_ph = M_IDLE; m_en = 0; m_age = 0; m_bits.delete();
        m_data = '0; m_valid = 0; m_hf = 0; m_rep = 0; m_prev = 0;
        m_vn_have = 0; m_vn_first = 0;
    endtask

    function automatic logic [63:0] pack_bits();
        logic [63:0] w;
        w = '0;
        foreach (m_bits[i]) w = (w << 1) | 64'(m_bits[i]);
        return w;
    endfunction

    task automatic model_step();
        bit strobe, pop, loaded, s;
        if (!reset_n) begin
            model_reset();
            return;
        end
        s      = trng_in;
        strobe = m_en && (((m_age + 1) % SD) == 0);
        pop    = m_valid && rready;
        loaded = 0;
        if (!enable) begin
            m_ph = M_IDLE; m_bits.delete(); m_rep = 0; m_hf = 0; m_vn_have = 0;
        end else begin
            case (m_ph)
                M_IDLE: m_ph = M_COLLECT;
                M_COLLECT: if (strobe) begin
                    if (feed.size() > 0) void'(feed.pop_front());
                    if (m_rep > 0 && s == m_prev) m_rep++; else m_rep = 1;
                    m_prev = s;
                    if (m_rep >= RL) begin
                        m_hf = 1; m_ph = M_FAIL; m_bits.delete(); m_vn_have = 0;
                    end else begin
`ifdef TRNG_VON_NEUMANN_EN
                        if (!m_vn_have) begin
                            m_vn_have = 1; m_vn_first = s;
                        end else begin
                            m_vn_have = 0;
                            if (m_vn_first != s) m_bits.push_back(m_vn_first);
                        end
`else
                        m_bits.push_back(s);
`endif
                        if (m_bits.size() == W) m_ph = M_HOLD;
                    end
                end
                M_HOLD: if (!m_valid || rready) begin
                    m_data = pack_bits(); m_valid = 1; loaded = 1;
                    m_bits.delete(); m_ph = M_COLLECT;
                end
                default: ;
            endcase
        end
        if (pop && !loaded) m_valid = 0;
        m_age = (enable && m_en) ? m_age + 1 : 0;
        m_en  = enable;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("trng_en", 64'(trng_en), 64'(m_en));
        chk("rvalid", 64'(rvalid), 64'(m_valid));
        chk("rdata", 64'(rdata), m_data);
        chk("health_fail", 64'(health_fail), 64'(m_hf));
        if (feed.size() > 0) trng_in = feed[0];
        else if (sticky) trng_in = ($urandom_range(15) == 0) ? ~trng_in : trng_in;
        else trng_in = 1'($urandom_range(1));
    endtask

    task automatic push_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) feed.push_back(w[i]);
    endtask

    task automatic wait_high(input string tag, input bit want_hf, input int budget, output int n);
        n = 0;
        while (((want_hf ? health_fail : rvalid) !== 1'b1) && n < budget) begin
            cyc();
            n++;
        end
        chk({tag, "_seen"}, 64'(want_hf ? health_fail : rvalid), 64'd1);
    endtask

    task automatic restart();
        enable = 1'b0;
        cyc();
        enable = 1'b1;
        cyc();
    endtask

    initial begin
        int n;
        model_reset();
        sticky  = 0;
        reset_n = 1'b0;
        enable  = 1'b0;
        rready  = 1'b0;
        trng_in = 1'b0;
        #12;
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_trng_en", 64'(trng_en), 64'd0);
        chk("rst_hf", 64'(health_fail), 64'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        cyc();

`ifndef TRNG_VON_NEUMANN_EN
        // Single word, consumer always ready.
        rready = 1'b1;
        push_word(32'hA5A5A5A5);
        restart();
        wait_high("t1_rvalid", 0, 400, n);
        chk("t1_rdata", 64'(rdata), 64'hA5A5A5A5);
        chk("t1_hf", 64'(health_fail), 64'd0);
        cyc();
        chk("t1_rvalid_pulse", 64'(rvalid), 64'd0);

        // Back-pressure: second word parks in HOLD until one pop.
        feed.delete();
        enable = 1'b0;
        cyc();
        rready = 1'b0;
        push_word(32'h0F0F0F0F);
        push_word(32'h33333333);
        enable = 1'b1;
        repeat (320) cyc();
        chk("t2_hold_rdata", 64'(rdata), 64'h0F0F0F0F);
        chk("t2_hold_rvalid", 64'(rvalid), 64'd1);
        rready = 1'b1;
        cyc();
        rready = 1'b0;
        chk("t2_swap_rdata", 64'(rdata), 64'h33333333);
        chk("t2_swap_rvalid", 64'(rvalid), 64'd1);
`endif

        // Constant input trips the health test on the RL-th strobe.
        feed.delete();
        rready = 1'b1;
        enable = 1'b0;
        cyc();
        rready = 1'b0;
        for (int i = 0; i < 40; i++) feed.push_back(1'b0);
        trng_in = 1'b0;
        enable  = 1'b1;
        cyc();
        wait_high("t3_hf", 1, 400, n);
        chk("t3_hf_cycles", 64'(n), 64'(RL * SD));
        chk("t3_no_word", 64'(rvalid), 64'd0);
        repeat (10) cyc();
        chk("t3_still_fail", 64'(health_fail), 64'd1);
        feed.delete();
        enable = 1'b0;
        cyc();
        chk("t3_hf_clear", 64'(health_fail), 64'd0);

`ifndef TRNG_VON_NEUMANN_EN
        // A partial word is discarded by enable=0.
        rready = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 10; i++) feed.push_back(1'($urandom_range(1)));
        n = 0;
        while (feed.size() > 0 && n < 200) begin cyc(); n++; end
        chk("t4_partial_fed", 64'(feed.size()), 64'd0);
        push_word(32'h12345678);
        restart();
        wait_high("t4_rvalid", 0, 400, n);
        chk("t4_rdata", 64'(rdata), 64'h12345678);
`else
        // Debiased pairs 10,01,00,11 give bits 1,0 only.
        rready = 1'b1;
        for (int g = 0; g < 16; g++) begin
            feed.push_back(1); feed.push_back(0); feed.push_back(0); feed.push_back(1);
            feed.push_back(0); feed.push_back(0); feed.push_back(1); feed.push_back(1);
        end
        restart();
        wait_high("t5_rvalid", 0, 800, n);
        chk("t5_rdata", 64'(rdata), 64'hAAAAAAAA);
`endif

        // Randomised traffic: random back-pressure, occasional disable,
        // then a sticky source that trips the health test repeatedly.
        feed.delete();
        for (int i = 0; i < 1600; i++) begin
            sticky = (i >= 800);
            rready = ($urandom_range(3) != 0);
            enable = ($urandom_range(199) != 0);
            cyc();
        end

        // Asynchronous reset while collecting with an unread word.
        sticky = 0;
        rready = 1'b0;
        restart();
        wait_high("t6_rvalid", 0, 1500, n);
        repeat (20) cyc();
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rvalid", 64'(rvalid), 64'd0);
        chk("t6_rdata", 64'(rdata), 64'd0);
        chk("t6_trng_en", 64'(trng_en), 64'd0);
        chk("t6_hf", 64'(health_fail), 64'd0);
        repeat (2) cyc();
        reset_n = 1'b1;
        repeat (20) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
